// File: rtl/sensor_regs_pkg.sv
// Shared address-map helpers for the sensor snapshot register bank.
// All map arithmetic lives here so the top and any future bus wrapper agree.
package sensor_regs_pkg;

  typedef logic [7:0] byte_t;

  localparam int SEQ_ADDR = 0;

  function automatic int bitmap_bytes(input int num_ch);
    return (num_ch + 7) / 8;
  endfunction

  function automatic int fresh_base(input int num_ch, input int ch_bytes);
    return 1 + num_ch * ch_bytes;
  endfunction

  function automatic int map_size(input int num_ch, input int ch_bytes);
    return num_ch * ch_bytes + 1 + bitmap_bytes(num_ch);
  endfunction

endpackage

// File: rtl/sensor_stale_timer.sv
// Per-channel freshness timer: counts cycles since the last strobe and
// saturates at STALE_CYC; fresh is registered alongside the counter.
module sensor_stale_timer #(
  parameter int STALE_CYC = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic strobe_i,
  output logic fresh_o
);

  localparam int CW = $clog2(STALE_CYC + 1);
  localparam logic [CW-1:0] SAT = CW'(STALE_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          fresh_q;

  // Next count: clear on strobe, otherwise climb until saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (strobe_i) begin
      cnt_d = '0;
    end else if (cnt_q != SAT) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and fresh flag registers; reset starts every channel stale.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= SAT;
      fresh_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fresh_q <= (cnt_d < SAT);
    end
  end

  assign fresh_o = fresh_q;

endmodule

// File: rtl/sensor_snapshot_regs.sv
// Sensor register bank: live channel copies, atomic shadow snapshot and a
// registered byte-wide read port so multi-byte values read back coherently.
module sensor_snapshot_regs
  import sensor_regs_pkg::*;
#(
  parameter int NUM_CH    = 12,
  parameter int CH_BYTES  = 2,
  parameter int ADDR_W    = 8,
  parameter int STALE_CYC = 1000,
  parameter int SEQ_W     = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_CH*CH_BYTES*8-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]            ch_valid_i,
  input  logic                         snap_req_i,
  input  logic                         rd_req_i,
  input  logic [ADDR_W-1:0]            rd_addr_i,
  output logic                         rd_ack_o,
  output logic [7:0]                   rd_data_o,
  output logic                         rd_err_o,
  output logic [7:0]                   snap_seq_o
);

  localparam int W     = CH_BYTES * 8;
  localparam int NB    = bitmap_bytes(NUM_CH);
  localparam int FBASE = fresh_base(NUM_CH, CH_BYTES);
  localparam int MSIZE = map_size(NUM_CH, CH_BYTES);

  logic [W-1:0]      live_q   [NUM_CH];
  logic [W-1:0]      shadow_q [NUM_CH];
  logic [NUM_CH-1:0] fresh_s;
  logic [NUM_CH-1:0] sfresh_q;
  logic [SEQ_W-1:0]  seq_q;
  logic [NB*8-1:0]   bitmap_s;
  logic              rd_ack_q;
  logic              rd_err_q;
  logic              rd_err_d;
  byte_t             rd_data_q;
  byte_t             rd_data_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
    sensor_stale_timer #(.STALE_CYC(STALE_CYC)) u_timer (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .strobe_i (ch_valid_i[g]),
      .fresh_o  (fresh_s[g])
    );
  end

  assign bitmap_s = (NB*8)'(sfresh_q);

  // Read mux over the shadow bank; only ever feeds the read registers.
  always_comb begin
    rd_data_d = 8'h00;
    rd_err_d  = (int'(rd_addr_i) >= MSIZE);
    if (int'(rd_addr_i) == SEQ_ADDR) begin
      rd_data_d = 8'(seq_q);
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < CH_BYTES; k++) begin
          if (int'(rd_addr_i) == 1 + c * CH_BYTES + k) begin
            rd_data_d = shadow_q[c][(CH_BYTES-1-k)*8 +: 8];
          end
        end
      end
      for (int b = 0; b < NB; b++) begin
        if (int'(rd_addr_i) == FBASE + b) begin
          rd_data_d = bitmap_s[b*8 +: 8];
        end
      end
    end
  end

  // Live bank, shadow bank and sequence counter; the shadow captures pre-edge
  // live values so a same-edge update lands in the following snapshot.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      sfresh_q <= '0;
      seq_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid_i[i]) begin
          live_q[i] <= ch_data_i[i*W +: W];
        end
      end
      if (snap_req_i) begin
        shadow_q <= live_q;
        sfresh_q <= fresh_s;
        seq_q    <= seq_q + SEQ_W'(1);
      end
    end
  end

  // Read response registers: data holds between acks, error is ack-qualified.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= 8'h00;
      rd_err_q  <= 1'b0;
    end else begin
      rd_ack_q <= rd_req_i;
      if (rd_req_i) begin
        rd_data_q <= rd_data_d;
        rd_err_q  <= rd_err_d;
      end else begin
        rd_err_q  <= 1'b0;
      end
    end
  end

  assign rd_ack_o   = rd_ack_q;
  assign rd_data_o  = rd_data_q;
  assign rd_err_o   = rd_err_q;
  assign snap_seq_o = 8'(seq_q);

endmodule

// File: tb/tb_sensor_snapshot_regs.sv
// Self-checking bench for sensor_snapshot_regs: a cycle-level model of the
// register map checked every cycle, plus directed reads with literal values.
module tb_sensor_snapshot_regs;

  localparam int NUM_CH    = 12;
  localparam int CH_BYTES  = 2;
  localparam int ADDR_W    = 8;
  localparam int STALE_CYC = 1000;
  localparam int CW        = CH_BYTES * 8;
  localparam int DATA_BASE = 1;
  localparam int BMAP_BASE = 1 + NUM_CH * CH_BYTES;
  localparam int BMAP_N    = (NUM_CH + 7) / 8;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [NUM_CH*CH_BYTES*8-1:0] ch_data;
  logic [NUM_CH-1:0]            ch_valid;
  logic                         snap_req;
  logic                         rd_req;
  logic [ADDR_W-1:0]            rd_addr;
  logic                         rd_ack;
  logic [7:0]                   rd_data;
  logic                         rd_err;
  logic [7:0]                   snap_seq;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: plain integers, updated once per rising edge.
  int     m_live   [NUM_CH];
  int     m_shadow [NUM_CH];
  bit     m_sfresh [NUM_CH];
  longint m_last   [NUM_CH];
  int     m_seq;
  longint m_e = 0;
  bit     e_ack;
  bit     e_err;
  int     e_data;

  sensor_snapshot_regs #(
    .NUM_CH(NUM_CH), .CH_BYTES(CH_BYTES), .ADDR_W(ADDR_W),
    .STALE_CYC(STALE_CYC), .SEQ_W(8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ch_data_i  (ch_data),
    .ch_valid_i (ch_valid),
    .snap_req_i (snap_req),
    .rd_req_i   (rd_req),
    .rd_addr_i  (rd_addr),
    .rd_ack_o   (rd_ack),
    .rd_data_o  (rd_data),
    .rd_err_o   (rd_err),
    .snap_seq_o (snap_seq)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One rising edge of the model: read from pre-edge shadow, then snapshot, then live update.
  task automatic model_step();
    bit fp [NUM_CH];
    int a;
    int bm;
    m_e++;
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_live[i] = 0; m_shadow[i] = 0; m_sfresh[i] = 1'b0; m_last[i] = -100000;
      end
      m_seq = 0; e_ack = 1'b0; e_data = 0; e_err = 1'b0;
    end else begin
      if (rd_req) begin
        e_ack = 1'b1;
        e_err = 1'b0;
        a = int'(rd_addr);
        if (a == 0) begin
          e_data = m_seq;
        end else if (a < BMAP_BASE) begin
          e_data = (m_shadow[(a - DATA_BASE) / CH_BYTES]
                    >> (8 * (CH_BYTES - 1 - (a - DATA_BASE) % CH_BYTES))) & 255;
        end else if (a < BMAP_BASE + BMAP_N) begin
          bm = 0;
          for (int i = 0; i < NUM_CH; i++) if (m_sfresh[i]) bm = bm | (1 << i);
          e_data = (bm >> (8 * (a - BMAP_BASE))) & 255;
        end else begin
          e_data = 0;
          e_err  = 1'b1;
        end
      end else begin
        e_ack = 1'b0;
        e_err = 1'b0;
      end
      for (int i = 0; i < NUM_CH; i++) fp[i] = (m_e - 1 - m_last[i]) < STALE_CYC;
      if (snap_req) begin
        for (int i = 0; i < NUM_CH; i++) begin
          m_shadow[i] = m_live[i];
          m_sfresh[i] = fp[i];
        end
        m_seq = (m_seq + 1) % 256;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i]) begin
          m_live[i] = int'(ch_data[i*CW +: CW]);
          m_last[i] = m_e;
        end
      end
    end
  endtask

  // Per-cycle compare against the model, 1 time unit after each rising edge.
  always @(posedge clk) begin
    model_step();
    #1;
    if (chk_en) begin
      check("cyc_rd_ack", 32'(rd_ack), 32'(e_ack));
      check("cyc_rd_err", 32'(rd_err), 32'(e_err));
      check("cyc_rd_data", 32'(rd_data), 32'(e_data));
      check("cyc_snap_seq", 32'(snap_seq), 32'(m_seq));
    end
  end

  task automatic rd(input logic [7:0] a, input logic [7:0] exp_d, input bit exp_e, input string nm);
    rd_req = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_req = 1'b0;
    check({nm, "_ack"}, 32'(rd_ack), 32'd1);
    check({nm, "_data"}, 32'(rd_data), 32'(exp_d));
    check({nm, "_err"}, 32'(rd_err), 32'(exp_e));
  endtask

  task automatic snap();
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
  endtask

  logic [7:0] t5_addr [4] = '{8'd25, 8'd26, 8'd27, 8'd255};
  bit         t5_err  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst_n = 1'b0; ch_data = '0; ch_valid = '0; snap_req = 1'b0; rd_req = 1'b0; rd_addr = 8'd0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: reset contents
    rd(8'd0, 8'h00, 1'b0, "t1_seq");
    rd(8'd1, 8'h00, 1'b0, "t1_ch0");
    rd(8'd25, 8'h00, 1'b0, "t1_bitmap");

    // 2: coherency of a two-byte channel across snapshots
    ch_data[15:0] = 16'h1234; ch_valid = 12'h001;
    @(negedge clk);
    ch_valid = 12'h000;
    snap();
    ch_data[15:0] = 16'hABCD; ch_valid = 12'h001;
    @(negedge clk);
    ch_valid = 12'h000;
    rd(8'd1, 8'h12, 1'b0, "t2_old_msb");
    rd(8'd2, 8'h34, 1'b0, "t2_old_lsb");
    snap();
    rd(8'd1, 8'hAB, 1'b0, "t2_new_msb");
    rd(8'd2, 8'hCD, 1'b0, "t2_new_lsb");
    rd(8'd0, 8'h02, 1'b0, "t2_seq");

    // 3: update and snapshot on the same edge
    ch_data[63:48] = 16'h5566; ch_valid = 12'h008; snap_req = 1'b1;
    @(negedge clk);
    ch_valid = 12'h000; snap_req = 1'b0;
    rd(8'd7, 8'h00, 1'b0, "t3_coll_msb");
    rd(8'd8, 8'h00, 1'b0, "t3_coll_lsb");
    snap();
    rd(8'd7, 8'h55, 1'b0, "t3_next_msb");
    rd(8'd8, 8'h66, 1'b0, "t3_next_lsb");

    // 4: staleness boundary; the second snap also carries a read of the bitmap
    ch_data[159:144] = 16'h0909; ch_valid = 12'h200;
    @(negedge clk);
    ch_valid = 12'h000;
    repeat (999) @(negedge clk);
    snap();
    snap_req = 1'b1; rd_req = 1'b1; rd_addr = 8'd26;
    @(negedge clk);
    snap_req = 1'b0; rd_req = 1'b0;
    check("t4_fresh_data", 32'(rd_data), 32'h02);
    check("t4_fresh_ack", 32'(rd_ack), 32'd1);
    rd(8'd26, 8'h00, 1'b0, "t4_stale");
    snap_req = 1'b1; rd_req = 1'b1; rd_addr = 8'd0;
    @(negedge clk);
    snap_req = 1'b0; rd_req = 1'b0;
    check("t4_seq_pre", 32'(rd_data), 32'h06);
    check("t4_seq_post", 32'(snap_seq), 32'h07);

    // 5: back-to-back reads including out-of-map addresses
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_addr = t5_addr[i];
      @(negedge clk);
      check("t5_ack", 32'(rd_ack), 32'd1);
      check("t5_data", 32'(rd_data), 32'h00);
      check("t5_err", 32'(rd_err), 32'(t5_err[i]));
    end
    rd_req = 1'b0;
    @(negedge clk);
    check("t5_idle_ack", 32'(rd_ack), 32'd0);
    check("t5_idle_err", 32'(rd_err), 32'd0);

    // 6: sequence wrap, then reset arriving with a read request
    snap_req = 1'b1;
    repeat (248) @(negedge clk);
    check("t6_seq_ff", 32'(snap_seq), 32'hFF);
    @(negedge clk);
    snap_req = 1'b0;
    check("t6_seq_wrap", 32'(snap_seq), 32'h00);
    rd(8'd1, 8'hAB, 1'b0, "t6_pre_rst");
    rd_req = 1'b1; rd_addr = 8'd1; rst_n = 1'b0;
    @(negedge clk);
    rd_req = 1'b0; rst_n = 1'b1;
    check("t6_rst_ack", 32'(rd_ack), 32'd0);
    check("t6_rst_data", 32'(rd_data), 32'h00);
    check("t6_rst_err", 32'(rd_err), 32'd0);
    check("t6_rst_seq", 32'(snap_seq), 32'h00);
    rd(8'd1, 8'h00, 1'b0, "t6_after_ch0");
    rd(8'd0, 8'h00, 1'b0, "t6_after_seq");

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
